// File: rtl/alu_seq_if.sv
// Request/result handshake bundle for alu_seq: operands and opcode in,
// registered result and flags out, each side with its own valid/ready pair.
interface alu_seq_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         c_in;
  logic [2:0]   ALUOp;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] overall_out;
  logic         c_out;
  logic         zero;
  logic         ovf;

  modport master (
    output in_valid, a, b, c_in, ALUOp, out_ready,
    input  in_ready, out_valid, overall_out, c_out, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, ALUOp, out_ready,
    output in_ready, out_valid, overall_out, c_out, zero, ovf
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arithmetic ops, iterative shift-add
// unsigned multiply, result and flags held until downstream accepts them.
module alu_seq #(
  parameter int N = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);
  localparam int CW = $clog2(N);

  typedef enum logic {S_IDLE, S_MUL} state_e;
  typedef enum logic [2:0] {
    OP_MOV = 3'b000, OP_NOT = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b011,
    OP_OR  = 3'b100, OP_AND = 3'b101, OP_SLT = 3'b110, OP_MUL = 3'b111
  } op_e;

  state_e         state_q, state_d;
  logic [N-1:0]   res_q, res_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;
  logic           valid_q, valid_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplr_q, mplr_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] acc_sum;
  logic           in_ready;

  op_e          op;
  logic [N:0]   add_w, sub_w;
  logic [N-1:0] alu_res;
  logic         alu_co, alu_ov;

  assign op = op_e'(bus.ALUOp);

  always_comb begin
    add_w   = {1'b0, bus.a} + {1'b0, bus.b} + (N+1)'(bus.c_in);
    sub_w   = {1'b0, bus.a} + {1'b0, ~bus.b} + (N+1)'(1);
    alu_res = '0;
    alu_co  = 1'b0;
    alu_ov  = 1'b0;
    case (op)
      OP_MOV: alu_res = bus.a;
      OP_NOT: alu_res = ~bus.a;
      OP_ADD: begin
        alu_res = add_w[N-1:0];
        alu_co  = add_w[N];
        alu_ov  = (bus.a[N-1] == bus.b[N-1]) && (add_w[N-1] != bus.a[N-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[N-1:0];
        alu_co  = sub_w[N];
        alu_ov  = (bus.a[N-1] != bus.b[N-1]) && (sub_w[N-1] != bus.a[N-1]);
      end
      OP_OR:  alu_res = bus.a | bus.b;
      OP_AND: alu_res = bus.a & bus.b;
      OP_SLT: alu_res = {{(N-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    valid_d  = valid_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    acc_sum  = acc_q;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = !valid_q || bus.out_ready;
        if (valid_q && bus.out_ready) valid_d = 1'b0;
        if (bus.in_valid && in_ready) begin
          if (op == OP_MUL) begin
            mcand_d = {{N{1'b0}}, bus.a};
            mplr_d  = bus.b;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_MUL;
          end else begin
            res_d   = alu_res;
            cout_d  = alu_co;
            ovf_d   = alu_ov;
            valid_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        // Multiplicand shifts left, multiplier right: bit i of b adds a<<i.
        acc_sum = mplr_q[0] ? acc_q + mcand_q : acc_q;
        acc_d   = acc_sum;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(N-1)) begin
          res_d   = acc_sum[N-1:0];
          cout_d  = |acc_sum[2*N-1:N];
          ovf_d   = 1'b0;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = valid_q;
  assign bus.overall_out = res_q;
  assign bus.c_out       = cout_q;
  assign bus.ovf         = ovf_q;
  assign bus.zero        = (res_q == '0);
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: N=32 and N=8 instances driven with directed
// and random operations, compared against an arithmetic reference model.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_seq_if #(.N(32)) b32();
  alu_seq_if #(.N(8))  b8();

  alu_seq #(.N(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  alu_seq #(.N(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [2:0] MOV = 3'd0, NOT = 3'd1, ADD = 3'd2, SUB = 3'd3,
                         OR_ = 3'd4, AND_ = 3'd5, SLT = 3'd6, MUL = 3'd7;

  // Reference: plain integer arithmetic on w-bit values held in 64 bits.
  function automatic void model(input int w, input logic [2:0] op,
                                input logic [63:0] a, input logic [63:0] b,
                                input logic cin, output logic [63:0] res,
                                output logic co, output logic ov);
    logic [63:0] m, p;
    longint sa, sb, ss, maxs, mins;
    m    = (64'd1 << w) - 64'd1;
    maxs = (longint'(1) << (w-1)) - 1;
    mins = -(longint'(1) << (w-1));
    sa   = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb   = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    res = '0; co = 1'b0; ov = 1'b0;
    case (op)
      MOV:  res = a;
      NOT:  res = ~a & m;
      ADD:  begin
        p = a + b + 64'(cin); res = p & m; co = ((p >> w) != 0);
        ss = sa + sb + longint'(cin); ov = (ss > maxs) || (ss < mins);
      end
      SUB:  begin
        res = (a - b) & m; co = (a >= b);
        ss = sa - sb; ov = (ss > maxs) || (ss < mins);
      end
      OR_:  res = a | b;
      AND_: res = a & b;
      SLT:  res = (sa < sb) ? 64'd1 : 64'd0;
      default: begin p = a * b; res = p & m; co = ((p >> w) != 0); end
    endcase
  endfunction

  task automatic drive(input int w, input logic v, input logic [2:0] op,
                       input logic [63:0] a, input logic [63:0] b, input logic cin);
    if (w == 32) begin
      b32.in_valid = v; b32.ALUOp = op; b32.a = a[31:0]; b32.b = b[31:0]; b32.c_in = cin;
    end else begin
      b8.in_valid = v; b8.ALUOp = op; b8.a = a[7:0]; b8.b = b[7:0]; b8.c_in = cin;
    end
  endtask

  task automatic set_ordy(input int w, input logic r);
    if (w == 32) b32.out_ready = r; else b8.out_ready = r;
  endtask

  task automatic sample(input int w, output logic [63:0] res, output logic co,
                        output logic ov, output logic zr, output logic vld, output logic rdy);
    if (w == 32) begin
      res = 64'(b32.overall_out); co = b32.c_out; ov = b32.ovf; zr = b32.zero;
      vld = b32.out_valid; rdy = b32.in_ready;
    end else begin
      res = 64'(b8.overall_out); co = b8.c_out; ov = b8.ovf; zr = b8.zero;
      vld = b8.out_valid; rdy = b8.in_ready;
    end
  endtask

  task automatic drive_garbage(input int w);
    drive(w, 1'b0, 3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
  endtask

  // Issue one op with out_ready high; returns the result once out_valid rises,
  // edges from accept to result, and whether in_ready stayed low meanwhile.
  task automatic run_op(input int w, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic cin, output logic [63:0] res,
                        output logic co, output logic ov, output logic zr,
                        output int lat, output logic rdy_low);
    logic vld, rdy;
    set_ordy(w, 1'b1);
    drive(w, 1'b1, op, a, b, cin);
    @(posedge clk); #1;
    drive_garbage(w);
    lat = 0; rdy_low = 1'b1;
    sample(w, res, co, ov, zr, vld, rdy);
    while (!vld && lat < 200) begin
      if (rdy) rdy_low = 1'b0;
      @(posedge clk); #1;
      lat++;
      drive_garbage(w);
      sample(w, res, co, ov, zr, vld, rdy);
    end
  endtask

  task automatic drain();
    drive(32, 1'b0, MOV, 64'd0, 64'd0, 1'b0); set_ordy(32, 1'b1);
    drive(8, 1'b0, MOV, 64'd0, 64'd0, 1'b0);  set_ordy(8, 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [63:0] res, er;
  logic co, ov, zr, eco, eov, rl;
  int lat;

  task automatic test_reset();
    rst_n = 1'b0;
    drain();
    n_checks++;
    if ({b32.out_valid, b32.overall_out, b32.c_out, b32.ovf, b32.zero, b32.in_ready} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1})
      $display("FAIL reset32: got v=%b r=%h c=%b o=%b z=%b rdy=%b want v=0 r=0 c=0 o=0 z=1 rdy=1",
               b32.out_valid, b32.overall_out, b32.c_out, b32.ovf, b32.zero, b32.in_ready);
    else n_pass++;
    n_checks++;
    if ({b8.out_valid, b8.overall_out, b8.zero, b8.in_ready} !== {1'b0, 8'd0, 1'b1, 1'b1})
      $display("FAIL reset8: got v=%b r=%h z=%b rdy=%b want v=0 r=0 z=1 rdy=1",
               b8.out_valid, b8.overall_out, b8.zero, b8.in_ready);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    run_op(32, ADD, 64'hFFFF_FFFF, 64'h1, 1'b0, res, co, ov, zr, lat, rl);
    n_checks++;
    if ({res, co, ov, zr, lat} !== {64'h0, 1'b1, 1'b0, 1'b1, 32'd0})
      $display("FAIL add_wrap: got r=%h c=%b o=%b z=%b lat=%0d want r=0 c=1 o=0 z=1 lat=0", res, co, ov, zr, lat);
    else n_pass++;
    run_op(32, ADD, 64'h7FFF_FFFF, 64'h1, 1'b0, res, co, ov, zr, lat, rl);
    n_checks++;
    if ({res, co, ov, zr} !== {64'h8000_0000, 1'b0, 1'b1, 1'b0})
      $display("FAIL add_ovf: got r=%h c=%b o=%b z=%b want r=80000000 c=0 o=1 z=0", res, co, ov, zr);
    else n_pass++;
    run_op(32, ADD, 64'h10, 64'h20, 1'b1, res, co, ov, zr, lat, rl);
    n_checks++;
    if ({res, co, ov} !== {64'h31, 1'b0, 1'b0})
      $display("FAIL add_cin: got r=%h c=%b o=%b want r=31 c=0 o=0", res, co, ov);
    else n_pass++;
  endtask

  task automatic test_sub_slt();
    run_op(32, SUB, 64'd5, 64'd7, 1'b0, res, co, ov, zr, lat, rl);
    n_checks++;
    if ({res, co, ov} !== {64'hFFFF_FFFE, 1'b0, 1'b0})
      $display("FAIL sub_borrow: got r=%h c=%b o=%b want r=fffffffe c=0 o=0", res, co, ov);
    else n_pass++;
    run_op(32, SLT, 64'hFFFF_FFFF, 64'd1, 1'b0, res, co, ov, zr, lat, rl);
    n_checks++;
    if ({res, co} !== {64'd1, 1'b0}) $display("FAIL slt_neg: got r=%h c=%b want r=1 c=0", res, co);
    else n_pass++;
    run_op(32, SLT, 64'd1, 64'hFFFF_FFFF, 1'b0, res, co, ov, zr, lat, rl);
    n_checks++;
    if ({res, zr} !== {64'd0, 1'b1}) $display("FAIL slt_pos: got r=%h z=%b want r=0 z=1", res, zr);
    else n_pass++;
  endtask

  task automatic test_mul();
    run_op(32, MUL, 64'h0001_0000, 64'h0001_0000, 1'b0, res, co, ov, zr, lat, rl);
    n_checks++;
    if ({res, co, ov, zr, lat, rl} !== {64'h0, 1'b1, 1'b0, 1'b1, 32'd32, 1'b1})
      $display("FAIL mul_ovf: got r=%h c=%b o=%b z=%b lat=%0d rdylow=%b want r=0 c=1 o=0 z=1 lat=32 rdylow=1",
               res, co, ov, zr, lat, rl);
    else n_pass++;
    run_op(32, MUL, 64'd123, 64'd456, 1'b0, res, co, ov, zr, lat, rl);
    n_checks++;
    if ({res, co, lat, rl} !== {64'd56088, 1'b0, 32'd32, 1'b1})
      $display("FAIL mul_small: got r=%0d c=%b lat=%0d rdylow=%b want r=56088 c=0 lat=32 rdylow=1", res, co, lat, rl);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] x, y, z;
    logic held;
    x = $urandom; y = $urandom; z = $urandom;
    drain();
    set_ordy(32, 1'b0);
    drive(32, 1'b1, MOV, 64'hA5, 64'd0, 1'b0);
    @(posedge clk); #1;
    drive(32, 1'b1, NOT, 64'(x), 64'd0, 1'b0);
    n_checks++;
    if ({b32.out_valid, b32.overall_out, b32.in_ready} !== {1'b1, 32'hA5, 1'b0})
      $display("FAIL bp_first: got v=%b r=%h rdy=%b want v=1 r=a5 rdy=0", b32.out_valid, b32.overall_out, b32.in_ready);
    else n_pass++;
    held = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (!b32.out_valid || b32.overall_out !== 32'hA5 || b32.in_ready !== 1'b0) held = 1'b0;
    end
    n_checks++;
    if (held !== 1'b1) $display("FAIL bp_hold: got held=%b want held=1", held);
    else n_pass++;
    set_ordy(32, 1'b1);
    @(posedge clk); #1;
    drive(32, 1'b1, OR_, 64'(y), 64'(z), 1'b0);
    n_checks++;
    if ({b32.out_valid, b32.overall_out} !== {1'b1, ~x})
      $display("FAIL bp_not: got v=%b r=%h want v=1 r=%h", b32.out_valid, b32.overall_out, ~x);
    else n_pass++;
    @(posedge clk); #1;
    drive(32, 1'b0, MOV, 64'd0, 64'd0, 1'b0);
    n_checks++;
    if ({b32.out_valid, b32.overall_out} !== {1'b1, y | z})
      $display("FAIL bp_or: got v=%b r=%h want v=1 r=%h", b32.out_valid, b32.overall_out, y | z);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (b32.out_valid !== 1'b0) $display("FAIL bp_drain: got v=%b want v=0", b32.out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_mul();
    logic stray;
    run_op(32, ADD, 64'd3, 64'd4, 1'b0, res, co, ov, zr, lat, rl);
    drive(32, 1'b1, MUL, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0);
    @(posedge clk); #1;
    drive(32, 1'b0, MOV, 64'd0, 64'd0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({b32.out_valid, b32.overall_out, b32.c_out, b32.ovf, b32.zero, b32.in_ready} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1})
      $display("FAIL rst_mul: got v=%b r=%h c=%b o=%b z=%b rdy=%b want v=0 r=0 c=0 o=0 z=1 rdy=1",
               b32.out_valid, b32.overall_out, b32.c_out, b32.ovf, b32.zero, b32.in_ready);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stray = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1) stray = 1'b1;
    end
    n_checks++;
    if (stray !== 1'b0) $display("FAIL rst_stray: got stray=%b want stray=0", stray);
    else n_pass++;
  endtask

  task automatic test_n8();
    run_op(8, MUL, 64'h10, 64'h10, 1'b0, res, co, ov, zr, lat, rl);
    n_checks++;
    if ({res, co, zr, lat, rl} !== {64'h0, 1'b1, 1'b1, 32'd8, 1'b1})
      $display("FAIL n8_mul: got r=%h c=%b z=%b lat=%0d rdylow=%b want r=0 c=1 z=1 lat=8 rdylow=1", res, co, zr, lat, rl);
    else n_pass++;
    run_op(8, ADD, 64'h80, 64'h80, 1'b0, res, co, ov, zr, lat, rl);
    n_checks++;
    if ({res, co, ov, zr} !== {64'h0, 1'b1, 1'b1, 1'b1})
      $display("FAIL n8_add: got r=%h c=%b o=%b z=%b want r=0 c=1 o=1 z=1", res, co, ov, zr);
    else n_pass++;
  endtask

  function automatic logic [63:0] rand_operand(input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 5))
      0: return m;
      1: return 64'd1 << (w-1);
      2: return 64'd0;
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  task automatic test_random();
    int w, elat;
    logic [2:0] op;
    logic [63:0] a, b;
    logic cin;
    for (int i = 0; i < 60; i++) begin
      w   = ($urandom_range(0, 1) != 0) ? 32 : 8;
      op  = 3'($urandom_range(0, 7));
      a   = rand_operand(w);
      b   = rand_operand(w);
      cin = 1'($urandom);
      model(w, op, a, b, (op == ADD) ? cin : 1'b0, er, eco, eov);
      elat = (op == MUL) ? w : 0;
      run_op(w, op, a, b, cin, res, co, ov, zr, lat, rl);
      n_checks++;
      if ({res, co, ov, zr, lat} !== {er, eco, eov, (er == 64'd0), elat})
        $display("FAIL rand%0d w=%0d op=%0d a=%h b=%h cin=%b: got r=%h c=%b o=%b z=%b lat=%0d want r=%h c=%b o=%b z=%b lat=%0d",
                 i, w, op, a, b, cin, res, co, ov, zr, lat, er, eco, eov, (er == 64'd0), elat);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_slt();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_n8();
    test_random();
    drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
